// File: rtl/buffer_drain_pkg.sv
// Shared types and constants for the buffer_drain reader stage.
// The SYNC state is always present in the enum; it only becomes reachable
// when BUFFER_DRAIN_SYNC_EN is defined at build time.
package buffer_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SYNC = 2'd2,
        SEND = 2'd3
    } state_e;

    // Framing byte sent ahead of every entry when sync framing is built in.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Every state other than IDLE has an entry in flight.
    function automatic logic state_is_busy(input state_e s);
        return (s != IDLE);
    endfunction

endpackage : buffer_drain_pkg

// File: rtl/buffer_drain_if.sv
// Bundle of the buffer read port, the write-pointer input, the byte stream and
// status lines of buffer_drain. The master modport is the drain itself; the
// slave modport is the surrounding buffer / stream consumer.
interface buffer_drain_if #(
    parameter int AW    = 16,
    parameter int BYTES = 4
);
    logic [AW-1:0]        write_addr;
    logic [AW-1:0]        read_addr;
    logic [8*BYTES-1:0]   read_data;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [AW-1:0]        pending;
    logic                 busy;

    modport master (
        input  write_addr,
        input  read_data,
        input  tx_ready,
        output read_addr,
        output tx_data,
        output tx_valid,
        output pending,
        output busy
    );

    modport slave (
        output write_addr,
        output read_data,
        output tx_ready,
        input  read_addr,
        input  tx_data,
        input  tx_valid,
        input  pending,
        input  busy
    );
endinterface : buffer_drain_if

// File: rtl/buffer_drain_entry_serializer.sv
// Serializes one buffer entry MSB-byte-first onto a valid/ready byte stream.
// A load pulse captures the entry; the block reports every accepted byte and
// flags the accept of the final payload byte. With BUFFER_DRAIN_SYNC_EN defined
// the constant SYNC_BYTE goes out ahead of the payload under the same handshake.
// tx_valid and tx_data are registers, so they never follow tx_ready
// combinationally and stay frozen while a byte waits for acceptance.
module entry_serializer
    import buffer_drain_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic [8*BYTES-1:0]   i_data,
    input  logic                 i_tx_ready,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    output logic                 o_accept,
    output logic                 o_last_accept
);
    localparam int DW = 8 * BYTES;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DW-1:0] r_shreg;
    logic [CW-1:0] r_byte_cnt;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;
    logic          w_accept;
    logic          w_last;
`ifdef BUFFER_DRAIN_SYNC_EN
    logic          r_sync;
`endif

    // Handshake decode: a byte moves when valid meets ready; last = final payload byte.
    always_comb begin
        w_accept = r_tx_valid & i_tx_ready;
`ifdef BUFFER_DRAIN_SYNC_EN
        w_last   = (r_byte_cnt == CW'(BYTES - 1)) & ~r_sync;
`else
        w_last   = (r_byte_cnt == CW'(BYTES - 1));
`endif
    end

    // Shift register, byte counter and registered stream outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg    <= {DW{1'b0}};
            r_byte_cnt <= {CW{1'b0}};
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
`ifdef BUFFER_DRAIN_SYNC_EN
            r_sync     <= 1'b0;
`endif
        end else if (i_load) begin
            r_shreg    <= i_data;
            r_byte_cnt <= {CW{1'b0}};
            r_tx_valid <= 1'b1;
`ifdef BUFFER_DRAIN_SYNC_EN
            r_sync     <= 1'b1;
            r_tx_data  <= SYNC_BYTE;
`else
            r_tx_data  <= i_data[DW-1 -: 8];
`endif
        end else if (w_accept) begin
`ifdef BUFFER_DRAIN_SYNC_EN
            if (r_sync) begin
                // Sync byte gone: present the untouched payload MSB next.
                r_sync    <= 1'b0;
                r_tx_data <= r_shreg[DW-1 -: 8];
            end else
`endif
            begin
                r_shreg    <= {r_shreg[DW-9:0], 8'h00};
                r_tx_data  <= r_shreg[DW-9 -: 8];
                r_byte_cnt <= r_byte_cnt + CW'(1);
                if (w_last) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_tx_valid <= 1'b1;
                end
            end
        end else begin
            r_shreg    <= r_shreg;
            r_byte_cnt <= r_byte_cnt;
            r_tx_valid <= r_tx_valid;
            r_tx_data  <= r_tx_data;
        end
    end

    assign o_tx_valid    = r_tx_valid;
    assign o_tx_data     = r_tx_data;
    assign o_accept      = w_accept;
    assign o_last_accept = w_accept & w_last;

endmodule : entry_serializer

// File: rtl/buffer_drain.sv
// buffer_drain: reader stage behind the dual-port capture buffer. Follows the
// upstream write pointer, fetches each unread entry through the combinational
// read port and hands it to entry_serializer for MSB-first byte output.
// Build option: define BUFFER_DRAIN_SYNC_EN to insert a SYNC state that sends
// SYNC_BYTE ahead of every entry. Default build has no sync framing.
// The ring holds 2**AW entries; a completely full ring reads as empty, so the
// upstream writer must keep fewer than 2**AW entries outstanding.
module buffer_drain
    import buffer_drain_pkg::*;
#(
    parameter int AW    = 16,
    parameter int BYTES = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    buffer_drain_if.master bus
);
    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_rd_ptr;
    logic          r_busy;
    logic          w_not_empty;
    logic          w_load;
    logic          w_accept;
    logic          w_last_accept;
    logic          w_tx_valid;
    logic [7:0]    w_tx_data;

    assign w_not_empty = (bus.write_addr != r_rd_ptr);

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; the next entry is checked against the already advanced pointer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_not_empty) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
`ifdef BUFFER_DRAIN_SYNC_EN
                w_state_nxt = SYNC;
`else
                w_state_nxt = SEND;
`endif
            end
            SYNC: begin
                if (w_accept) begin
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = SYNC;
                end
            end
            SEND: begin
                if (w_last_accept) begin
                    if (w_not_empty) begin
                        w_state_nxt = LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = SEND;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM output decode: LOAD captures the addressed entry for exactly one cycle.
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            LOAD:    w_load = 1'b1;
            default: w_load = 1'b0;
        endcase
    end

    // Read pointer advances on every LOAD and wraps naturally at 2**AW.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= {AW{1'b0}};
        end else if (w_load) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
        end else begin
            r_rd_ptr <= r_rd_ptr;
        end
    end

    // Busy flag registered from the upcoming state so it lines up with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= state_is_busy(w_state_nxt);
        end
    end

    entry_serializer #(
        .BYTES (BYTES)
    ) u_ser (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_load        (w_load),
        .i_data        (bus.read_data),
        .i_tx_ready    (bus.tx_ready),
        .o_tx_valid    (w_tx_valid),
        .o_tx_data     (w_tx_data),
        .o_accept      (w_accept),
        .o_last_accept (w_last_accept)
    );

    assign bus.read_addr = r_rd_ptr;
    assign bus.pending   = bus.write_addr - r_rd_ptr;
    assign bus.tx_valid  = w_tx_valid;
    assign bus.tx_data   = w_tx_data;
    assign bus.busy      = r_busy;

endmodule : buffer_drain

// File: tb/tb_buffer_drain.sv
// Scoreboard bench for buffer_drain (AW=4, BYTES=4) with a behavioural buffer.
// Stimulus pushes the expected byte stream of every entry it releases; a
// negedge monitor pops and compares on each handshake and checks hold stability.
module tb_buffer_drain;
    localparam int AW    = 4;
    localparam int BYTES = 4;
`ifdef BUFFER_DRAIN_SYNC_EN
    localparam int WIRE  = BYTES + 1;
`else
    localparam int WIRE  = BYTES;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ram [0:15];
    logic [7:0]  exp_q [$];
    int          checks  = 0;
    int          fails   = 0;
    int          n_acc   = 0;

    buffer_drain_if #(.AW(AW), .BYTES(BYTES)) bus ();

    buffer_drain #(.AW(AW), .BYTES(BYTES)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    assign bus.read_data = ram[bus.read_addr];

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_entry(input logic [31:0] w);
`ifdef BUFFER_DRAIN_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        for (int b = 0; b < BYTES; b++) begin
            exp_q.push_back(w[31 - 8*b -: 8]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Bounded wait for the drain to go quiet with every expected byte seen.
    task automatic wait_idle(input string name, input int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            if (!bus.busy && !bus.tx_valid && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, done}, 32'd1);
        step(1);
    endtask

    // Monitor: compare every accepted byte and check held bytes stay put.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    always @(negedge clock) begin
        logic [7:0] e;
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
                chk("hold_data", {24'd0, bus.tx_data}, {24'd0, hold_d});
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte_queue_size", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {24'd0, bus.tx_data}, {24'd0, e});
                    n_acc++;
                end
            end
            hold_v = bus.tx_valid && !bus.tx_ready;
            hold_d = bus.tx_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] pat;
        logic [3:0]  pend_exp [0:4];
        logic [3:0]  last_p;
        int          idx;
        int          base;
        logic [7:0]  first_b;

        for (int i = 0; i < 16; i++) ram[i] = 32'h01020304 + 32'(i) * 32'h10101010;
        ram[0] = 32'h11223344;
        ram[1] = 32'h55667788;
        bus.write_addr = 4'd0;
        bus.tx_ready   = 1'b0;

        // 1: reset, then 20 idle cycles with nothing to read.
        step(3);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("t1_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
            chk("t1_pending", {28'd0, bus.pending}, 32'd0);
            chk("t1_read_addr", {28'd0, bus.read_addr}, 32'd0);
            chk("t1_busy", {31'd0, bus.busy}, 32'd0);
        end
        step(1);

        // 2: single entry, ready held high; first byte two cycles after write_addr moves.
`ifdef BUFFER_DRAIN_SYNC_EN
        first_b = 8'hA5;
`else
        first_b = 8'h11;
`endif
        bus.tx_ready   = 1'b1;
        bus.write_addr = 4'd1;
        push_entry(ram[0]);
        @(negedge clock);
        chk("t2_pending_before", {28'd0, bus.pending}, 32'd1);
        chk("t2_valid_cyc0", {31'd0, bus.tx_valid}, 32'd0);
        step(1);
        @(negedge clock);
        chk("t2_valid_load", {31'd0, bus.tx_valid}, 32'd0);
        chk("t2_busy_load", {31'd0, bus.busy}, 32'd1);
        step(1);
        @(negedge clock);
        chk("t2_valid_first", {31'd0, bus.tx_valid}, 32'd1);
        chk("t2_first_byte", {24'd0, bus.tx_data}, {24'd0, first_b});
        chk("t2_read_addr_mid", {28'd0, bus.read_addr}, 32'd1);
        step(WIRE);
        @(negedge clock);
        chk("t2_valid_end", {31'd0, bus.tx_valid}, 32'd0);
        chk("t2_busy_end", {31'd0, bus.busy}, 32'd0);
        chk("t2_read_addr", {28'd0, bus.read_addr}, 32'd1);
        chk("t2_pending", {28'd0, bus.pending}, 32'd0);
        chk("t2_all_bytes", 32'(exp_q.size()), 32'd0);
        step(1);

        // 3: ready toggled by a fixed pattern while an entry is sent.
        pat = 20'b1001_0110_0011_0101_1001;
        bus.tx_ready   = 1'b0;
        bus.write_addr = 4'd2;
        push_entry(ram[1]);
        for (int i = 0; i < 20; i++) begin
            bus.tx_ready = pat[i];
            step(1);
        end
        bus.tx_ready = 1'b1;
        wait_idle("t3_done", 40);
        chk("t3_read_addr", {28'd0, bus.read_addr}, 32'd2);

        // Drain entries 2..13 to park the read pointer at 14.
        bus.write_addr = 4'd14;
        for (int i = 2; i < 14; i++) push_entry(ram[i]);
        wait_idle("drain_done", 200);
        chk("drain_read_addr", {28'd0, bus.read_addr}, 32'd14);

        // 4: four entries across the ring wrap, pending counts down 4..0.
        pend_exp[0] = 4'd4; pend_exp[1] = 4'd3; pend_exp[2] = 4'd2;
        pend_exp[3] = 4'd1; pend_exp[4] = 4'd0;
        bus.write_addr = 4'd2;
        push_entry(ram[14]);
        push_entry(ram[15]);
        push_entry(ram[0]);
        push_entry(ram[1]);
        idx    = 0;
        last_p = 4'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (idx == 0 || bus.pending != last_p) begin
                if (idx < 5) chk("t4_pending_seq", {28'd0, bus.pending}, {28'd0, pend_exp[idx]});
                else chk("t4_pending_extra", {28'd0, bus.pending}, 32'd0);
                idx++;
                last_p = bus.pending;
            end
            if (idx >= 5 && !bus.busy && !bus.tx_valid) break;
        end
        chk("t4_pending_steps", 32'(idx), 32'd5);
        chk("t4_all_bytes", 32'(exp_q.size()), 32'd0);
        chk("t4_read_addr", {28'd0, bus.read_addr}, 32'd2);
        step(1);

        // 5: reset in the middle of an entry drops it; entry 0 is resent from byte 0.
        reset_n = 1'b0;
        step(2);
        bus.write_addr = 4'd1;
        reset_n = 1'b1;
        push_entry(ram[0]);
        base = n_acc;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (n_acc >= base + 2) break;
        end
        chk("t5_two_accepted", 32'(n_acc - base), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("t5_valid_in_reset", {31'd0, bus.tx_valid}, 32'd0);
        chk("t5_busy_in_reset", {31'd0, bus.busy}, 32'd0);
        chk("t5_addr_in_reset", {28'd0, bus.read_addr}, 32'd0);
        exp_q.delete();
        push_entry(ram[0]);
        step(2);
        reset_n = 1'b1;
        wait_idle("t5_resend_done", 40);
        chk("t5_read_addr", {28'd0, bus.read_addr}, 32'd1);

        // 6: DEADBEEF entry (sync byte first when framing is built in).
        ram[1] = 32'hDEADBEEF;
        bus.write_addr = 4'd2;
        push_entry(ram[1]);
        wait_idle("t6_done", 40);
        chk("t6_read_addr", {28'd0, bus.read_addr}, 32'd2);
        chk("t6_pending", {28'd0, bus.pending}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_buffer_drain
